// File: rtl/unidade_cp_pkg.sv
// Shared types for the program-counter unit: FSM state encoding and the
// next-PC source selector used by the address mux.
package cp_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } estado_t;

    typedef enum logic [2:0] {
        INC,
        BRANCH,
        JUMP,
        JR,
        POP,
        VECTOR,
        HOLD
    } sel_pc_t;

endpackage

// File: rtl/unidade_cp_pilha.sv
// Return-address stack: a small LIFO holding link addresses for Call/Ret
// and interrupt entry/exit. Pushes into a full stack and pops from an empty
// stack are silently ignored here; the caller flags them as errors.
module pilha_retorno #(
    parameter int ADDR_WIDTH  = 10,
    parameter int STACK_DEPTH = 4,
    localparam int CW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] dado_i,
    output logic [ADDR_WIDTH-1:0] topo_o,
    output logic                  cheia_o,
    output logic                  vazia_o,
    output logic [CW-1:0]         contagem_o
);

    localparam int IW = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] memoria_q [STACK_DEPTH];
    logic [CW-1:0]         contagem_q;
    logic [CW-1:0]         topoPos;

    assign cheia_o    = (contagem_q == CW'(STACK_DEPTH));
    assign vazia_o    = (contagem_q == '0);
    assign contagem_o = contagem_q;

    // Top entry sits one below the count; its value is meaningless when empty.
    assign topoPos = contagem_q - CW'(1);
    assign topo_o  = memoria_q[topoPos[IW-1:0]];

    // Occupancy tracking; only the count needs a reset to empty the stack.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_q <= '0;
        end else if (push_i && !cheia_o) begin
            contagem_q <= contagem_q + CW'(1);
        end else if (pop_i && !vazia_o) begin
            contagem_q <= contagem_q - CW'(1);
        end
    end

    // Storage write at the first free slot; while not full the count fits IW bits.
    always_ff @(posedge clock) begin
        if (push_i && !cheia_o) begin
            memoria_q[contagem_q[IW-1:0]] <= dado_i;
        end
    end

endmodule

// File: rtl/unidade_cp.sv
// Program-counter unit: next-address selection with signed branches,
// jumps, register jumps, call/return through a hardware stack, stall/halt
// control and a single maskable interrupt with a fixed vector.
module unidade_cp
    import cp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int STACK_DEPTH = 4,
    parameter int INT_VECTOR  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] desvio_condicional,
    input  logic [ADDR_WIDTH-1:0] desvio_incondicional,
    input  logic [ADDR_WIDTH-1:0] leitura1,
    input  logic                  Branch,
    input  logic                  BranchNE,
    input  logic                  Jump,
    input  logic                  Jr,
    input  logic                  Call,
    input  logic                  Ret,
    input  logic                  Reti,
    input  logic                  zero,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  resume,
    input  logic                  irq,
    output logic [ADDR_WIDTH-1:0] cp,
    output logic [ADDR_WIDTH-1:0] cp_mais1,
    output logic                  irq_ack,
    output logic                  parado,
    output logic                  int_en,
    output logic                  pilha_overflow,
    output logic                  pilha_underflow
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] cp_q, cp_d;
    logic                  intEn_q, intEn_d;
    logic                  irqAck_q, irqAck_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    sel_pc_t               selNormal, selPc;
    logic                  pushNormal, popNormal, retiNormal;
    logic [ADDR_WIDTH-1:0] alvoNormal;
    logic [ADDR_WIDTH-1:0] pcMais1;
    logic                  desvioTomado;

    logic                  pilhaPush, pilhaPop;
    logic [ADDR_WIDTH-1:0] pilhaDado, pilhaTopo;
    logic                  pilhaCheia, pilhaVazia;
    logic [CW-1:0]         pilhaContagem;

    pilha_retorno #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_pilha (
        .clock     (clock),
        .reset     (reset),
        .push_i    (pilhaPush),
        .pop_i     (pilhaPop),
        .dado_i    (pilhaDado),
        .topo_o    (pilhaTopo),
        .cheia_o   (pilhaCheia),
        .vazia_o   (pilhaVazia),
        .contagem_o(pilhaContagem)
    );

    assign pcMais1      = cp_q + ADDR_WIDTH'(1);
    assign desvioTomado = (Branch && zero) || (BranchNE && !zero);

    // Sequential (non-interrupt) next address, following the control priority.
    // The offset is two's complement, so plain modular addition handles negatives.
    always_comb begin
        selNormal  = INC;
        pushNormal = 1'b0;
        popNormal  = 1'b0;
        retiNormal = 1'b0;
        if (desvioTomado) begin
            selNormal = BRANCH;
        end else if (Call) begin
            selNormal  = JUMP;
            pushNormal = 1'b1;
        end else if (Jump) begin
            selNormal = JUMP;
        end else if (Ret) begin
            selNormal = POP;
            popNormal = 1'b1;
        end else if (Reti) begin
            selNormal  = POP;
            popNormal  = 1'b1;
            retiNormal = 1'b1;
        end else if (Jr) begin
            selNormal = JR;
        end

        case (selNormal)
            BRANCH:  alvoNormal = pcMais1 + desvio_condicional;
            JUMP:    alvoNormal = desvio_incondicional;
            JR:      alvoNormal = leitura1;
            POP:     alvoNormal = pilhaVazia ? pcMais1 : pilhaTopo;
            default: alvoNormal = pcMais1;
        endcase
    end

    // Decide this cycle's action from the FSM state, and derive stack traffic,
    // interrupt-enable and sticky error flags from it.
    always_comb begin
        selPc       = HOLD;
        pilhaPush   = 1'b0;
        pilhaPop    = 1'b0;
        pilhaDado   = pcMais1;
        estado_d    = estado_q;
        intEn_d     = intEn_q;
        irqAck_d    = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (estado_q)
            RUN: begin
                if (!stall) begin
                    if (irq && intEn_q) begin
                        selPc     = VECTOR;
                        pilhaPush = 1'b1;
                        pilhaDado = alvoNormal;
                        intEn_d   = 1'b0;
                        irqAck_d  = 1'b1;
                    end else if (halt) begin
                        estado_d = HALT;
                    end else begin
                        selPc     = selNormal;
                        pilhaPush = pushNormal;
                        pilhaPop  = popNormal;
                        if (retiNormal) begin
                            intEn_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                if (irq && intEn_q) begin
                    selPc     = VECTOR;
                    pilhaPush = 1'b1;
                    pilhaDado = cp_q;
                    intEn_d   = 1'b0;
                    irqAck_d  = 1'b1;
                    estado_d  = RUN;
                end else if (resume) begin
                    estado_d = RUN;
                end
            end
            default: estado_d = RUN;
        endcase

        if (pilhaPush && pilhaCheia) begin
            overflow_d = 1'b1;
        end
        if (pilhaPop && pilhaVazia) begin
            underflow_d = 1'b1;
        end

        case (selPc)
            VECTOR:  cp_d = ADDR_WIDTH'(INT_VECTOR);
            HOLD:    cp_d = cp_q;
            default: cp_d = alvoNormal;
        endcase
    end

    // FSM and registered outputs; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= RUN;
            cp_q        <= '0;
            intEn_q     <= 1'b1;
            irqAck_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cp_q        <= cp_d;
            intEn_q     <= intEn_d;
            irqAck_q    <= irqAck_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The stack can never report more entries than it physically holds.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (pilhaContagem <= CW'(STACK_DEPTH));
        end
    end

    assign cp              = cp_q;
    assign cp_mais1        = pcMais1;
    assign irq_ack         = irqAck_q;
    assign parado          = (estado_q == HALT);
    assign int_en          = intEn_q;
    assign pilha_overflow  = overflow_q;
    assign pilha_underflow = underflow_q;

endmodule

// File: tb/tb_unidade_cp.sv
// Scoreboard bench for unidade_cp: directed stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them.
module tb_unidade_cp;

    localparam int AW = 10;

    logic          clock;
    logic          reset;
    logic [AW-1:0] desvio_condicional;
    logic [AW-1:0] desvio_incondicional;
    logic [AW-1:0] leitura1;
    logic          Branch, BranchNE, Jump, Jr, Call, Ret, Reti;
    logic          zero, stall, halt, resume, irq;
    logic [AW-1:0] cp, cp_mais1;
    logic          irq_ack, parado, int_en, pilha_overflow, pilha_underflow;

    typedef struct {
        int            due;
        string         nome;
        logic [AW-1:0] cp;
        logic          ack;
        logic          par;
        logic          ien;
        logic          ovf;
        logic          und;
    } esperado_t;

    esperado_t filaEsperada[$];
    int        cycleCount = 0;
    int        checks     = 0;
    int        fails      = 0;
    logic      expParado, expIntEn, expOvf, expUnd;

    unidade_cp #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(4),
        .INT_VECTOR (1)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .desvio_condicional  (desvio_condicional),
        .desvio_incondicional(desvio_incondicional),
        .leitura1            (leitura1),
        .Branch              (Branch),
        .BranchNE            (BranchNE),
        .Jump                (Jump),
        .Jr                  (Jr),
        .Call                (Call),
        .Ret                 (Ret),
        .Reti                (Reti),
        .zero                (zero),
        .stall               (stall),
        .halt                (halt),
        .resume              (resume),
        .irq                 (irq),
        .cp                  (cp),
        .cp_mais1            (cp_mais1),
        .irq_ack             (irq_ack),
        .parado              (parado),
        .int_en              (int_en),
        .pilha_overflow      (pilha_overflow),
        .pilha_underflow     (pilha_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic setIdle();
        reset = 1'b0;
        desvio_condicional = '0;
        desvio_incondicional = '0;
        leitura1 = '0;
        Branch = 1'b0; BranchNE = 1'b0; Jump = 1'b0; Jr = 1'b0;
        Call = 1'b0; Ret = 1'b0; Reti = 1'b0;
        zero = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0; irq = 1'b0;
    endtask

    // Caller has already driven the controls; record what must appear after the edge.
    task automatic applyStimulus(input string nome, input int expCp, input logic expAck);
        esperado_t e;
        e.due  = cycleCount + 1;
        e.nome = nome;
        e.cp   = AW'(expCp);
        e.ack  = expAck;
        e.par  = expParado;
        e.ien  = expIntEn;
        e.ovf  = expOvf;
        e.und  = expUnd;
        filaEsperada.push_back(e);
        @(posedge clock);
        #1;
        setIdle();
    endtask

    task automatic doJump(input int alvo);
        Jump = 1'b1;
        desvio_incondicional = AW'(alvo);
        applyStimulus("jump", alvo, 1'b0);
    endtask

    task automatic doCall(input string nome, input int alvo);
        Call = 1'b1;
        desvio_incondicional = AW'(alvo);
        applyStimulus(nome, alvo, 1'b0);
    endtask

    task automatic doRet(input string nome, input int expCp);
        Ret = 1'b1;
        applyStimulus(nome, expCp, 1'b0);
    endtask

    task automatic checkOutput(input esperado_t e);
        logic [AW-1:0] expM1;
        expM1 = e.cp + AW'(1);
        checks++;
        if (e.due != cycleCount || cp !== e.cp || cp_mais1 !== expM1 ||
            irq_ack !== e.ack || parado !== e.par || int_en !== e.ien ||
            pilha_overflow !== e.ovf || pilha_underflow !== e.und) begin
            fails++;
            $display("[TB] FAIL %s: got cp=%0d cp_mais1=%0d ack=%b parado=%b int_en=%b ovf=%b und=%b cycle=%0d; expected cp=%0d cp_mais1=%0d ack=%b parado=%b int_en=%b ovf=%b und=%b cycle=%0d",
                     e.nome, cp, cp_mais1, irq_ack, parado, int_en, pilha_overflow,
                     pilha_underflow, cycleCount, e.cp, expM1, e.ack, e.par, e.ien,
                     e.ovf, e.und, e.due);
        end
    endtask

    // Monitor: compare the oldest expectation once its result edge has passed.
    always @(negedge clock) begin
        if (filaEsperada.size() > 0 && filaEsperada[0].due <= cycleCount) begin
            checkOutput(filaEsperada.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setIdle();
        reset = 1'b1;
        expParado = 1'b0; expIntEn = 1'b1; expOvf = 1'b0; expUnd = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus("reset", 0, 1'b0);

        // Sequential increment and wrap at the top of the address space.
        for (int i = 1; i <= 4; i++) applyStimulus("idle", i, 1'b0);
        doJump(1023);
        applyStimulus("wrap", 0, 1'b0);

        // Conditional branches with a negative and a positive offset.
        doJump(20);
        BranchNE = 1'b1; zero = 1'b0; desvio_condicional = 10'h3FB;
        applyStimulus("bne_taken", 16, 1'b0);
        doJump(20);
        BranchNE = 1'b1; zero = 1'b1; desvio_condicional = 10'h3FB;
        applyStimulus("bne_not_taken", 21, 1'b0);
        Branch = 1'b1; zero = 1'b1; desvio_condicional = 10'd3;
        applyStimulus("beq_taken", 25, 1'b0);
        Branch = 1'b1; zero = 1'b0; desvio_condicional = 10'd3;
        applyStimulus("beq_not_taken", 26, 1'b0);
        Jr = 1'b1; leitura1 = 10'd777;
        applyStimulus("jr", 777, 1'b0);

        // Call/return, nesting to overflow, then draining to underflow.
        doJump(8);
        doCall("call", 100);
        doRet("ret", 9);
        doCall("call_n1", 200);
        doCall("call_n2", 300);
        doCall("call_n3", 400);
        doCall("call_n4", 500);
        expOvf = 1'b1;
        doCall("call_overflow", 600);
        doRet("ret_n4", 401);
        doRet("ret_n3", 301);
        doRet("ret_n2", 201);
        doRet("ret_n1", 10);
        expUnd = 1'b1;
        doRet("ret_underflow", 11);

        // Interrupt preempting a jump, masking, and return via Reti.
        doJump(30);
        irq = 1'b1; Jump = 1'b1; desvio_incondicional = 10'd50;
        expIntEn = 1'b0;
        applyStimulus("irq_take", 1, 1'b1);
        irq = 1'b1;
        applyStimulus("irq_masked", 2, 1'b0);
        Reti = 1'b1;
        expIntEn = 1'b1;
        applyStimulus("reti", 50, 1'b0);

        // Stall freezes everything, deferring irq and ignoring halt.
        for (int i = 0; i < 3; i++) begin
            irq = 1'b1; stall = 1'b1; halt = (i == 1);
            applyStimulus("stall", 50, 1'b0);
        end
        irq = 1'b1;
        expIntEn = 1'b0;
        applyStimulus("irq_after_stall", 1, 1'b1);
        Reti = 1'b1;
        expIntEn = 1'b1;
        applyStimulus("reti2", 51, 1'b0);

        // Halt, resume, interrupt out of halt, reset out of halt.
        doJump(12);
        halt = 1'b1; expParado = 1'b1;
        applyStimulus("halt", 12, 1'b0);
        applyStimulus("halted_idle", 12, 1'b0);
        stall = 1'b1;
        applyStimulus("halted_stall", 12, 1'b0);
        resume = 1'b1; expParado = 1'b0;
        applyStimulus("resume", 12, 1'b0);
        applyStimulus("after_resume", 13, 1'b0);
        halt = 1'b1; expParado = 1'b1;
        applyStimulus("halt2", 13, 1'b0);
        irq = 1'b1; expParado = 1'b0; expIntEn = 1'b0;
        applyStimulus("irq_in_halt", 1, 1'b1);
        Reti = 1'b1; expIntEn = 1'b1;
        applyStimulus("reti3", 13, 1'b0);
        halt = 1'b1; expParado = 1'b1;
        applyStimulus("halt3", 13, 1'b0);
        reset = 1'b1; resume = 1'b1;
        expParado = 1'b0; expOvf = 1'b0; expUnd = 1'b0;
        applyStimulus("reset_in_halt", 0, 1'b0);
        applyStimulus("post_reset", 1, 1'b0);

        // Reset with a full stack must empty it.
        doCall("fill1", 100);
        doCall("fill2", 200);
        doCall("fill3", 300);
        doCall("fill4", 400);
        expOvf = 1'b1;
        doCall("fill_overflow", 500);
        reset = 1'b1; Ret = 1'b1;
        expOvf = 1'b0;
        applyStimulus("reset_full", 0, 1'b0);
        expUnd = 1'b1;
        doRet("ret_after_reset", 1);

        repeat (3) @(posedge clock);
        #1;
        while (filaEsperada.size() > 0) begin
            esperado_t e;
            e = filaEsperada.pop_front();
            checks++;
            fails++;
            $display("[TB] FAIL %s: got no comparison by cycle %0d, expected one at cycle %0d",
                     e.nome, cycleCount, e.due);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
